// File: rtl/alu_exec_if.sv
// Issue and result buses between the reservation station, alu_exec and the CDB arbiter.
// The master side is the RS/arbiter pair; the slave side is the execution unit.
interface alu_exec_if;
  logic        alu_en;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_funct3;
  logic        alu_funct7;
  logic [31:0] alu_val1;
  logic [31:0] alu_val2;
  logic [31:0] alu_imm;
  logic [31:0] alu_pc;
  logic [3:0]  alu_rob_pos;
  logic        alu_busy;
  logic        cdb_grant;
  logic        res_valid;
  logic [3:0]  res_rob_pos;
  logic [31:0] res_val;
  logic        res_jump;
  logic [31:0] res_pc;

  modport master (
    output alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
           alu_imm, alu_pc, alu_rob_pos, cdb_grant,
    input  alu_busy, res_valid, res_rob_pos, res_val, res_jump, res_pc
  );

  modport slave (
    input  alu_en, alu_opcode, alu_funct3, alu_funct7, alu_val1, alu_val2,
           alu_imm, alu_pc, alu_rob_pos, cdb_grant,
    output alu_busy, res_valid, res_rob_pos, res_val, res_jump, res_pc
  );
endinterface

// File: rtl/alu_exec.sv
// Single-cycle RV32I integer execution unit with an in-order result queue feeding the CDB,
// branch/jump resolution and an issue throttle back to the reservation station.
module alu_exec #(
  parameter int FIFO_DEPTH = 2,
  parameter int PTR_W      = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rdy,
  input  logic       rollback,
  alu_exec_if.slave  bus,
  output logic       ovf
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [PTR_W:0] COUNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] COUNT_BUSY = (PTR_W+1)'(FIFO_DEPTH - 1);

  logic [31:0] op2;
  logic [4:0]  shamt;
  logic [31:0] arith;
  logic        taken;
  logic [31:0] calc_val;
  logic        calc_jump;
  logic [31:0] calc_pc;

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic             full;
  logic             enq_req;
  logic             enq;
  logic             deq;

  logic [3:0]  mem_rob  [FIFO_DEPTH];
  logic [31:0] mem_val  [FIFO_DEPTH];
  logic        mem_jump [FIFO_DEPTH];
  logic [31:0] mem_pc   [FIFO_DEPTH];

  always_comb begin
    op2   = (bus.alu_opcode == OPC_OP) ? bus.alu_val2 : bus.alu_imm;
    shamt = op2[4:0];
    arith = '0;
    case (bus.alu_funct3)
      // Only register-register ADD may become SUB; ADDI ignores instr[30].
      3'b000: arith = (bus.alu_opcode == OPC_OP && bus.alu_funct7) ?
                      bus.alu_val1 - op2 : bus.alu_val1 + op2;
      3'b001: arith = bus.alu_val1 << shamt;
      3'b010: arith = {31'b0, $signed(bus.alu_val1) < $signed(op2)};
      3'b011: arith = {31'b0, bus.alu_val1 < op2};
      3'b100: arith = bus.alu_val1 ^ op2;
      3'b101: arith = bus.alu_funct7 ? 32'($signed(bus.alu_val1) >>> shamt) :
                      bus.alu_val1 >> shamt;
      3'b110: arith = bus.alu_val1 | op2;
      default: arith = bus.alu_val1 & op2;
    endcase

    taken = 1'b0;
    case (bus.alu_funct3)
      3'b000: taken = bus.alu_val1 == bus.alu_val2;
      3'b001: taken = bus.alu_val1 != bus.alu_val2;
      3'b100: taken = $signed(bus.alu_val1) <  $signed(bus.alu_val2);
      3'b101: taken = $signed(bus.alu_val1) >= $signed(bus.alu_val2);
      3'b110: taken = bus.alu_val1 <  bus.alu_val2;
      3'b111: taken = bus.alu_val1 >= bus.alu_val2;
      default: taken = 1'b0;
    endcase

    calc_val  = '0;
    calc_jump = 1'b0;
    calc_pc   = bus.alu_pc + 32'd4;
    case (bus.alu_opcode)
      OPC_LUI:   calc_val = bus.alu_imm;
      OPC_AUIPC: calc_val = bus.alu_pc + bus.alu_imm;
      OPC_OP,
      OPC_OPIMM: calc_val = arith;
      OPC_JAL: begin
        calc_val  = bus.alu_pc + 32'd4;
        calc_jump = 1'b1;
        calc_pc   = bus.alu_pc + bus.alu_imm;
      end
      OPC_JALR: begin
        calc_val  = bus.alu_pc + 32'd4;
        calc_jump = 1'b1;
        calc_pc   = (bus.alu_val1 + bus.alu_imm) & ~32'd1;
      end
      OPC_BRANCH: begin
        calc_jump = taken;
        if (taken) calc_pc = bus.alu_pc + bus.alu_imm;
      end
      default: ;
    endcase
  end

  // A full queue still accepts an entry when the head leaves in the same cycle.
  assign full    = (count == COUNT_FULL);
  assign enq_req = rdy && bus.alu_en && !rollback;
  assign deq     = rdy && bus.res_valid && bus.cdb_grant && !rollback;
  assign enq     = enq_req && (!full || deq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else if (rollback) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      if (enq && !deq)      count <= count + (PTR_W+1)'(1);
      else if (deq && !enq) count <= count - (PTR_W+1)'(1);
      if (enq_req && full && !deq) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem_rob[tail]  <= bus.alu_rob_pos;
      mem_val[tail]  <= calc_val;
      mem_jump[tail] <= calc_jump;
      mem_pc[tail]   <= calc_pc;
    end
  end

  // Payload is forced to zero while empty since the storage itself is never cleared.
  assign bus.res_valid   = (count != '0);
  assign bus.res_rob_pos = bus.res_valid ? mem_rob[head]  : '0;
  assign bus.res_val     = bus.res_valid ? mem_val[head]  : '0;
  assign bus.res_jump    = bus.res_valid ? mem_jump[head] : 1'b0;
  assign bus.res_pc      = bus.res_valid ? mem_pc[head]   : '0;
  assign bus.alu_busy    = (count >= COUNT_BUSY);

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed scenarios followed by randomized traffic,
// all compared against a queue-based behavioural model of the execution unit.
module tb_alu_exec;

  localparam int DEPTH = 2;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;

  typedef struct {
    logic [3:0]  rob;
    logic [31:0] val;
    logic        jump;
    logic [31:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rdy = 1'b1;
  logic rollback = 1'b0;
  logic ovf;

  alu_exec_if bus ();

  alu_exec dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus.slave),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  entry_t model_q[$];
  logic   model_ovf = 1'b0;
  int     tests = 0;
  int     fails = 0;

  function automatic entry_t ref_exec(input logic [6:0] op, input logic [2:0] f3,
                                      input logic f7, input logic [31:0] a,
                                      input logic [31:0] b, input logic [31:0] imm,
                                      input logic [31:0] pc, input logic [3:0] rob);
    entry_t e;
    logic [31:0] y;
    logic alt;
    logic tk;
    e.rob = rob; e.val = 0; e.jump = 0; e.pc = pc + 4;
    y   = (op == OP) ? b : imm;
    alt = f7 && (op == OP || f3 == 3'd5);
    if (op == LUI) e.val = imm;
    else if (op == AUIPC) e.val = pc + imm;
    else if (op == OP || op == OPIMM) begin
      case (f3)
        3'd0: e.val = alt ? a - y : a + y;
        3'd1: e.val = a << y[4:0];
        3'd2: e.val = ($signed(a) < $signed(y)) ? 1 : 0;
        3'd3: e.val = (a < y) ? 1 : 0;
        3'd4: e.val = a ^ y;
        3'd5: e.val = alt ? 32'($signed(a) >>> y[4:0]) : a >> y[4:0];
        3'd6: e.val = a | y;
        default: e.val = a & y;
      endcase
    end else if (op == JAL) begin
      e.val = pc + 4; e.jump = 1; e.pc = pc + imm;
    end else if (op == JALR) begin
      e.val = pc + 4; e.jump = 1; e.pc = (a + imm) & 32'hFFFF_FFFE;
    end else if (op == BRANCH) begin
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = $signed(a) < $signed(b);
        3'd5: tk = $signed(a) >= $signed(b);
        3'd6: tk = a < b;
        3'd7: tk = a >= b;
        default: tk = 0;
      endcase
      e.jump = tk;
      if (tk) e.pc = pc + imm;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("res_valid", bus.res_valid, model_q.size() != 0);
    check("alu_busy", bus.alu_busy, model_q.size() >= DEPTH - 1);
    check("ovf", ovf, model_ovf);
    if (model_q.size() != 0) begin
      check("res_rob_pos", bus.res_rob_pos, model_q[0].rob);
      check("res_val", bus.res_val, model_q[0].val);
      check("res_jump", bus.res_jump, model_q[0].jump);
      check("res_pc", bus.res_pc, model_q[0].pc);
    end else begin
      check("empty_val", bus.res_val, 0);
      check("empty_pc", bus.res_pc, 0);
    end
  endtask

  task automatic model_step();
    bit deq;
    bit full;
    if (rollback) model_q.delete();
    else if (rdy) begin
      deq  = (model_q.size() != 0) && bus.cdb_grant;
      full = (model_q.size() == DEPTH);
      if (bus.alu_en && full && !deq) model_ovf = 1'b1;
      if (deq) void'(model_q.pop_front());
      if (bus.alu_en && (!full || deq))
        model_q.push_back(ref_exec(bus.alu_opcode, bus.alu_funct3, bus.alu_funct7,
                                   bus.alu_val1, bus.alu_val2, bus.alu_imm,
                                   bus.alu_pc, bus.alu_rob_pos));
    end
  endtask

  task automatic apply_stimulus(input logic en, input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, input logic [31:0] v1, input logic [31:0] v2,
                                input logic [31:0] imm, input logic [31:0] pc,
                                input logic [3:0] rob, input logic grant);
    bus.alu_en = en; bus.alu_opcode = op; bus.alu_funct3 = f3; bus.alu_funct7 = f7;
    bus.alu_val1 = v1; bus.alu_val2 = v2; bus.alu_imm = imm; bus.alu_pc = pc;
    bus.alu_rob_pos = rob; bus.cdb_grant = grant;
    model_step();
    @(posedge clk);
    #1;
    check_output();
  endtask

  task automatic idle(input logic grant);
    apply_stimulus(1'b0, 7'd0, 3'd0, 1'b0, 0, 0, 0, 0, 4'd0, grant);
  endtask

  task automatic addi(input logic [3:0] rob, input logic [31:0] v, input logic grant);
    apply_stimulus(1'b1, OPIMM, 3'd0, 1'b1, v, 0, 32'd1, 32'h200, rob, grant);
  endtask

  initial begin
    logic [6:0] ops [8];
    logic [31:0] v1;
    ops = '{LUI, AUIPC, OP, OPIMM, JAL, JALR, BRANCH, 7'b0000000};

    bus.alu_en = 0; bus.alu_opcode = 0; bus.alu_funct3 = 0; bus.alu_funct7 = 0;
    bus.alu_val1 = 0; bus.alu_val2 = 0; bus.alu_imm = 0; bus.alu_pc = 0;
    bus.alu_rob_pos = 0; bus.cdb_grant = 0;
    #2 rst_n = 1'b0;
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output();
    check("reset_rob", bus.res_rob_pos, 0);

    // SUB 5-7 then grant
    apply_stimulus(1'b1, OP, 3'd0, 1'b1, 32'd5, 32'd7, 0, 0, 4'd3, 1'b0);
    check("sub_val", bus.res_val, 32'hFFFF_FFFE);
    check("sub_rob", bus.res_rob_pos, 4'd3);
    check("sub_jump", bus.res_jump, 0);
    idle(1'b1);
    check("granted_empty", bus.res_valid, 0);

    // BLT taken, then BLTU not taken replacing it in the same cycle
    apply_stimulus(1'b1, BRANCH, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd4, 1'b1);
    check("blt_jump", bus.res_jump, 1);
    check("blt_pc", bus.res_pc, 32'h120);
    apply_stimulus(1'b1, BRANCH, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 4'd5, 1'b1);
    check("bltu_jump", bus.res_jump, 0);
    check("bltu_pc", bus.res_pc, 32'h104);

    // JALR and SRAI
    apply_stimulus(1'b1, JALR, 3'd0, 1'b0, 32'h1001, 0, 32'd2, 32'h40, 4'd6, 1'b1);
    check("jalr_val", bus.res_val, 32'h44);
    check("jalr_pc", bus.res_pc, 32'h1002);
    check("jalr_jump", bus.res_jump, 1);
    apply_stimulus(1'b1, OPIMM, 3'd5, 1'b1, 32'h8000_0000, 0, 32'd4, 32'h44, 4'd7, 1'b1);
    check("srai_val", bus.res_val, 32'hF800_0000);
    idle(1'b1);

    // Full queue with simultaneous enqueue and grant
    addi(4'd1, 32'd10, 1'b0);
    addi(4'd2, 32'd20, 1'b0);
    addi(4'd3, 32'd30, 1'b1);
    check("swap_head", bus.res_rob_pos, 4'd2);
    check("swap_ovf", ovf, 0);
    idle(1'b1);
    check("swap_tail", bus.res_rob_pos, 4'd3);
    idle(1'b1);

    // Backpressure and overflow
    addi(4'd1, 32'd100, 1'b0);
    check("bp_busy", bus.alu_busy, 1);
    addi(4'd2, 32'd200, 1'b0);
    check("bp_head", bus.res_rob_pos, 4'd1);
    addi(4'd9, 32'd300, 1'b0);
    check("bp_ovf", ovf, 1);
    check("bp_head_kept", bus.res_rob_pos, 4'd1);
    idle(1'b1);
    check("drain1", bus.res_rob_pos, 4'd2);
    idle(1'b1);

    // rdy low holds everything
    addi(4'd5, 32'd7, 1'b0);
    rdy = 1'b0;
    addi(4'd6, 32'd8, 1'b1);
    check("hold_rob", bus.res_rob_pos, 4'd5);
    rdy = 1'b1;

    // Rollback with two entries and a pending issue
    addi(4'd6, 32'd8, 1'b0);
    rollback = 1'b1;
    addi(4'd7, 32'd9, 1'b0);
    rollback = 1'b0;
    check("rb_valid", bus.res_valid, 0);
    check("rb_busy", bus.alu_busy, 0);
    check("rb_ovf", ovf, 1);

    // Asynchronous reset between edges
    addi(4'd8, 32'd1, 1'b0);
    rst_n = 1'b0;
    #2;
    model_q.delete();
    model_ovf = 1'b0;
    check("arst_valid", bus.res_valid, 0);
    check("arst_busy", bus.alu_busy, 0);
    check("arst_ovf", ovf, 0);
    check("arst_val", bus.res_val, 0);
    #5 rst_n = 1'b1;
    idle(1'b0);

    for (int i = 0; i < 400; i++) begin
      rdy      = ($urandom_range(0, 7) != 0);
      rollback = ($urandom_range(0, 29) == 0);
      v1 = $urandom;
      apply_stimulus($urandom_range(0, 2) != 0, ops[$urandom_range(0, 7)],
                     3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), v1,
                     ($urandom_range(0, 3) == 0) ? v1 : $urandom,
                     ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom,
                     $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
    end
    rdy = 1'b1;
    rollback = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
